// File: rtl/fastica_pkg.sv
// Shared definitions for the fastica fixed-point blocks: FSM encoding, default
// data format and the positive saturation limit of a W-bit signed value.
package fastica_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } rsq_state_t;

    localparam int RSQ_W    = 26;
    localparam int RSQ_FRAC = 13;

    localparam logic [RSQ_W-1:0] RSQ_SAT_MAX = {1'b0, {(RSQ_W-1){1'b1}}};

endpackage

// File: rtl/row_sq_sum_sq_sat.sv
// Square of one fixed-point element, rescaled by FRAC and clamped to 0..2^(W-1)-1.
// Purely combinational; no flow control.
module sq_sat
    import fastica_pkg::*;
#(
    parameter int W    = RSQ_W,
    parameter int FRAC = RSQ_FRAC
) (
    input  logic signed [W-1:0] i_e,
    output logic        [W-1:0] o_sq
);

    localparam logic [W-1:0] SAT_MAX = (W == RSQ_W) ? RSQ_SAT_MAX : {1'b0, {(W-1){1'b1}}};

    logic signed [2*W-1:0] w_ext;
    logic signed [2*W-1:0] w_prod;
    logic signed [2*W-1:0] w_shift;

    // The exact product of two W-bit signed values always fits in 2W bits.
    assign w_ext   = {{W{i_e[W-1]}}, i_e};
    assign w_prod  = w_ext * w_ext;
    assign w_shift = w_prod >>> FRAC;

    always_comb begin
        o_sq = w_shift[W-1:0];
        if (w_shift[2*W-1]) begin
            o_sq = '0;
        end else if ($unsigned(w_shift) > {{W{1'b0}}, SAT_MAX}) begin
            o_sq = SAT_MAX;
        end
    end

endmodule

// File: rtl/row_sq_sum.sv
// Squared Euclidean norm of each row of a latched 4x4 fixed-point matrix.
// One element per cycle; done_rsq pulses 17 cycles after start is sampled; start ignored while busy.
module row_sq_sum
    import fastica_pkg::*;
#(
    parameter int W    = RSQ_W,
    parameter int FRAC = RSQ_FRAC
) (
    input  logic                clk_rsq,
    input  logic                rst_rsq,
    input  logic                start_rsq,
    input  logic signed [W-1:0] i11, i12, i13, i14,
    input  logic signed [W-1:0] i21, i22, i23, i24,
    input  logic signed [W-1:0] i31, i32, i33, i34,
    input  logic signed [W-1:0] i41, i42, i43, i44,
    output logic                busy_rsq,
    output logic                done_rsq,
    output logic signed [W-1:0] o11, o12, o13, o14,
    output logic signed [W-1:0] o21, o22, o23, o24,
    output logic signed [W-1:0] o31, o32, o33, o34,
    output logic signed [W-1:0] o41, o42, o43, o44,
    output logic signed [W-1:0] sum1, sum2, sum3, sum4
);

    localparam logic [W-1:0] SAT_MAX = (W == RSQ_W) ? RSQ_SAT_MAX : {1'b0, {(W-1){1'b1}}};

    rsq_state_t         r_state;
    rsq_state_t         w_next;
    logic signed [W-1:0] w_in  [16];
    logic signed [W-1:0] r_mat [16];
    logic        [W-1:0] r_acc [4];
    logic        [W-1:0] r_sum [4];
    logic        [3:0]   r_cnt;
    logic                r_done;
    logic        [W-1:0] w_sq;
    logic        [W:0]   w_acc_sum;
    logic        [W-1:0] w_acc_nxt;

    assign w_in[0]  = i11; assign w_in[1]  = i12; assign w_in[2]  = i13; assign w_in[3]  = i14;
    assign w_in[4]  = i21; assign w_in[5]  = i22; assign w_in[6]  = i23; assign w_in[7]  = i24;
    assign w_in[8]  = i31; assign w_in[9]  = i32; assign w_in[10] = i33; assign w_in[11] = i34;
    assign w_in[12] = i41; assign w_in[13] = i42; assign w_in[14] = i43; assign w_in[15] = i44;

    always_ff @(posedge clk_rsq) begin
        if (rst_rsq) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start_rsq) w_next = ST_MAC;
            ST_MAC:  if (r_cnt == 4'd15) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_rsq = (r_state == ST_MAC);
        done_rsq = r_done;
    end

    sq_sat #(.W(W), .FRAC(FRAC)) u_sq_sat (
        .i_e  (r_mat[r_cnt]),
        .o_sq (w_sq)
    );

    // Both operands are at most SAT_MAX, so one extra bit cannot overflow.
    assign w_acc_sum = {1'b0, r_acc[r_cnt[3:2]]} + {1'b0, w_sq};
    assign w_acc_nxt = (w_acc_sum > {1'b0, SAT_MAX}) ? SAT_MAX : w_acc_sum[W-1:0];

    always_ff @(posedge clk_rsq) begin
        if (rst_rsq) begin
            for (int i = 0; i < 16; i++) r_mat[i] <= '0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= '0;
                r_sum[i] <= '0;
            end
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_rsq) begin
                        for (int i = 0; i < 16; i++) r_mat[i] <= w_in[i];
                        for (int i = 0; i < 4; i++) r_acc[i] <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_MAC: begin
                    r_acc[r_cnt[3:2]] <= w_acc_nxt;
                    if (r_cnt != 4'd15) r_cnt <= r_cnt + 4'd1;
                end
                ST_DONE: begin
                    for (int i = 0; i < 4; i++) r_sum[i] <= r_acc[i];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o11 = r_mat[0];  assign o12 = r_mat[1];  assign o13 = r_mat[2];  assign o14 = r_mat[3];
    assign o21 = r_mat[4];  assign o22 = r_mat[5];  assign o23 = r_mat[6];  assign o24 = r_mat[7];
    assign o31 = r_mat[8];  assign o32 = r_mat[9];  assign o33 = r_mat[10]; assign o34 = r_mat[11];
    assign o41 = r_mat[12]; assign o42 = r_mat[13]; assign o43 = r_mat[14]; assign o44 = r_mat[15];

    assign sum1 = r_sum[0];
    assign sum2 = r_sum[1];
    assign sum3 = r_sum[2];
    assign sum4 = r_sum[3];

endmodule

// File: tb/tb_row_sq_sum.sv
// Randomized scoreboard bench for row_sq_sum: stimulus pushes expected results,
// a negedge monitor pops and compares on every done_rsq pulse.
module tb_row_sq_sum;

    localparam longint LIM = 33554431;

    typedef logic [15:0][25:0] mat_t;
    typedef logic [3:0][25:0]  sums_t;
    typedef struct packed {
        mat_t  m;
        sums_t s;
        int    due;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_rsq;
    logic  start_rsq;
    mat_t  m_in;
    mat_t  o_p;
    sums_t s_p;
    logic  busy_rsq, done_rsq;

    int    cyc = 0;
    int    idle_from = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    exp_t  q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    row_sq_sum dut (
        .clk_rsq(clk), .rst_rsq(rst_rsq), .start_rsq(start_rsq),
        .i11(m_in[0]),  .i12(m_in[1]),  .i13(m_in[2]),  .i14(m_in[3]),
        .i21(m_in[4]),  .i22(m_in[5]),  .i23(m_in[6]),  .i24(m_in[7]),
        .i31(m_in[8]),  .i32(m_in[9]),  .i33(m_in[10]), .i34(m_in[11]),
        .i41(m_in[12]), .i42(m_in[13]), .i43(m_in[14]), .i44(m_in[15]),
        .busy_rsq(busy_rsq), .done_rsq(done_rsq),
        .o11(o_p[0]),  .o12(o_p[1]),  .o13(o_p[2]),  .o14(o_p[3]),
        .o21(o_p[4]),  .o22(o_p[5]),  .o23(o_p[6]),  .o24(o_p[7]),
        .o31(o_p[8]),  .o32(o_p[9]),  .o33(o_p[10]), .o34(o_p[11]),
        .o41(o_p[12]), .o42(o_p[13]), .o43(o_p[14]), .o44(o_p[15]),
        .sum1(s_p[0]), .sum2(s_p[1]), .sum3(s_p[2]), .sum4(s_p[3])
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: squared row norms with clamping, in plain integer arithmetic.
    function automatic sums_t model(input mat_t m);
        sums_t  res;
        longint acc, e, sq;
        for (int r = 0; r < 4; r++) begin
            acc = 0;
            for (int c = 0; c < 4; c++) begin
                e  = longint'($signed(m[r*4+c]));
                sq = (e * e) >>> 13;
                if (sq < 0)   sq = 0;
                if (sq > LIM) sq = LIM;
                acc = acc + sq;
                if (acc > LIM) acc = LIM;
            end
            res[r] = acc[25:0];
        end
        return res;
    endfunction

    function automatic logic [25:0] rnd_elem();
        int t;
        case ($urandom_range(0, 3))
            0:       t = int'($urandom());
            1:       t = 0;
            default: t = int'($urandom_range(0, 32768)) - 16384;
        endcase
        return t[25:0];
    endfunction

    function automatic mat_t fill(input int v);
        mat_t m;
        for (int i = 0; i < 16; i++) m[i] = v[25:0];
        return m;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_rsq && done_rsq) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done at cycle %0d: done_rsq=1, required no pulse", cyc);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.due);
                for (int r = 0; r < 4; r++) chk($sformatf("sum%0d", r + 1), s_p[r], e.s[r]);
                for (int i = 0; i < 16; i++) chk($sformatf("o%0d%0d", i / 4 + 1, i % 4 + 1), o_p[i], e.m[i]);
            end
        end
    end

    // Caller sits just after a rising edge; start is sampled on the next edge.
    task automatic start_job(input mat_t m, output int n);
        exp_t e;
        m_in = m;
        start_rsq = 1'b1;
        n = cyc + 1;
        if (n >= idle_from) begin
            e.m = m;
            e.s = model(m);
            e.due = n + 17;
            q.push_back(e);
            idle_from = n + 18;
        end
        @(posedge clk); #1;
        start_rsq = 1'b0;
    endtask

    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy_rsq, 0);
        chk({tag, "_done"}, done_rsq, 0);
        for (int r = 0; r < 4; r++) chk($sformatf("%s_sum%0d", tag, r + 1), s_p[r], 0);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_o%0d", tag, i), o_p[i], 0);
    endtask

    task automatic job(input mat_t m);
        int n;
        goto(idle_from - 1);
        start_job(m, n);
        goto(n + 8);
        @(negedge clk);
        chk("busy_in_mac", busy_rsq, 1);
        goto(n + 16);
        @(negedge clk);
        chk("busy_in_done", busy_rsq, 0);
        chk("done_early", done_rsq, 0);
        goto(n + 17);
    endtask

    initial begin : stim
        mat_t  m, a;
        sums_t sa;
        int    n, d;

        rst_rsq = 1'b1;
        start_rsq = 1'b1;
        m_in = fill(1234);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst_rsq = 1'b0;
        start_rsq = 1'b0;
        idle_from = cyc + 1;

        m = '0;
        for (int i = 0; i < 16; i += 5) m[i] = 26'd8192;
        job(m);
        job(fill(-4096));
        job(fill(4096));
        job(fill(33554431));
        m = '0;
        for (int i = 4; i < 8; i++) m[i] = 26'd33554431;
        job(m);
        job(fill(-33554432));

        // Starts during MAC and on the last MAC edge are dropped.
        a = fill(3000);
        a[7] = 26'd9999;
        goto(idle_from - 1);
        start_job(a, n);
        goto(n + 2);
        start_job(fill(-777), d);
        goto(n + 15);
        start_job(fill(20000), d);
        m_in = fill(555);
        goto(n + 20);

        // Reset in the middle of MAC step 8 aborts without a done pulse.
        goto(idle_from - 1);
        start_job(fill(8192), n);
        goto(n + 8);
        rst_rsq = 1'b1;
        q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk_zero("abort");
        @(posedge clk); #1;
        rst_rsq = 1'b0;
        idle_from = cyc + 1;
        goto(cyc + 25);
        m = '0;
        for (int i = 0; i < 16; i++) m[i] = 26'(i * 1000 - 7000);
        job(m);

        // Back-to-back: second start sampled on the edge after done_rsq rises.
        a = '0;
        for (int i = 0; i < 16; i++) a[i] = rnd_elem();
        sa = model(a);
        goto(idle_from - 1);
        start_job(a, n);
        goto(n + 17);
        for (int i = 0; i < 16; i++) m[i] = rnd_elem();
        start_job(m, d);
        goto(d + 5);
        @(negedge clk);
        for (int r = 0; r < 4; r++) chk($sformatf("hold_sum%0d", r + 1), s_p[r], sa[r]);
        goto(d + 17);

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 16; i++) m[i] = rnd_elem();
            goto(idle_from - 1 + int'($urandom_range(0, 3)));
            start_job(m, n);
        end

        goto(idle_from + 3);
        chk("pending_results", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout at cycle %0d: bench did not complete", cyc);
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

endmodule
